// File: rtl/reg_writeback_if.sv
// reg_writeback_if: bundles the ALU result, the load handshake and the
// register-file write port of reg_writeback.
//   master : drives the ALU/load inputs, observes the write port and status
//   slave  : the write-back block itself
// Signals: i_alu_valid/i_alu_rd/i_alu_val, i_ld_valid/o_ld_ready/i_ld_rd/
//          i_ld_val, o_w_reg_num/o_w_val/o_op, o_pending, o_count.
interface reg_writeback_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            i_alu_valid;
   logic [4:0]      i_alu_rd;
   logic [XLEN-1:0] i_alu_val;
   logic            i_ld_valid;
   logic            o_ld_ready;
   logic [4:0]      i_ld_rd;
   logic [XLEN-1:0] i_ld_val;
   logic [4:0]      o_w_reg_num;
   logic [XLEN-1:0] o_w_val;
   logic            o_op;
   logic [31:0]     o_pending;
   logic [CW-1:0]   o_count;

   modport master (
      output i_alu_valid, i_alu_rd, i_alu_val,
      output i_ld_valid, i_ld_rd, i_ld_val,
      input  o_ld_ready, o_w_reg_num, o_w_val, o_op, o_pending, o_count
   );

   modport slave (
      input  i_alu_valid, i_alu_rd, i_alu_val,
      input  i_ld_valid, i_ld_rd, i_ld_val,
      output o_ld_ready, o_w_reg_num, o_w_val, o_op, o_pending, o_count
   );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: drives the register file's single write port from the ALU
// and the load unit. ALU results always win and are never stalled; loads that
// collide wait in an ordered circular queue. An ALU write kills any queued
// load to the same register, since the ALU result is younger.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : reg_writeback_if.slave (ALU in, load handshake, write port,
//             pending-register mask, queue occupancy)
module reg_writeback #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input logic             i_clk,
   input logic             i_rst_n,
   reg_writeback_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [4:0]      r_q_rd  [DEPTH];
   logic [XLEN-1:0] r_q_val [DEPTH];
   logic [DEPTH-1:0] r_q_live;
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;

   logic            r_op;
   logic [4:0]      r_w_reg_num;
   logic [XLEN-1:0] r_w_val;

   logic            w_ld_ready;
   logic            w_ld_acc;
   logic            w_alu_sel;
   logic            w_pop;
   logic            w_direct;
   logic            w_ld_same;
   logic            w_push;
   logic [31:0]     w_pending;
   logic [PW-1:0]   w_off;

   assign w_ld_ready = (r_count < DEPTH_C);
   assign w_ld_acc   = bus.i_ld_valid & w_ld_ready;
   assign w_alu_sel  = bus.i_alu_valid & (bus.i_alu_rd != 5'd0);
   assign w_pop      = ~w_alu_sel & (r_count != '0);
   assign w_direct   = ~w_alu_sel & (r_count == '0) & w_ld_acc & (bus.i_ld_rd != 5'd0);
   // a load racing an ALU write to the same register is older: drop it
   assign w_ld_same  = w_alu_sel & (bus.i_ld_rd == bus.i_alu_rd);
   assign w_push     = w_ld_acc & (bus.i_ld_rd != 5'd0) & ~w_direct & ~w_ld_same;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_q_live <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q_rd[i]  <= '0;
            r_q_val[i] <= '0;
         end
      end else begin
         if (w_alu_sel) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (r_q_rd[i] == bus.i_alu_rd) r_q_live[i] <= 1'b0;
            end
         end
         if (w_pop) begin
            r_q_live[r_rptr] <= 1'b0;
            r_rptr           <= r_rptr + PW'(1);
         end
         // push never lands on the head being popped: that would need count
         // to be 0 (no pop) or DEPTH (no push)
         if (w_push) begin
            r_q_rd[r_wptr]   <= bus.i_ld_rd;
            r_q_val[r_wptr]  <= bus.i_ld_val;
            r_q_live[r_wptr] <= 1'b1;
            r_wptr           <= r_wptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_op        <= 1'b0;
         r_w_reg_num <= '0;
         r_w_val     <= '0;
      end else if (w_alu_sel) begin
         r_op        <= 1'b1;
         r_w_reg_num <= bus.i_alu_rd;
         r_w_val     <= bus.i_alu_val;
      end else if (w_pop) begin
         // a killed head still consumes its slot, but produces no strobe
         r_op <= r_q_live[r_rptr];
         if (r_q_live[r_rptr]) begin
            r_w_reg_num <= r_q_rd[r_rptr];
            r_w_val     <= r_q_val[r_rptr];
         end
      end else if (w_direct) begin
         r_op        <= 1'b1;
         r_w_reg_num <= bus.i_ld_rd;
         r_w_val     <= bus.i_ld_val;
      end else begin
         r_op <= 1'b0;
      end
   end

   // only entries between the read pointer and read pointer + count are valid
   always_comb begin
      w_pending = '0;
      w_off     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_off = PW'(i) - r_rptr;
         if (r_q_live[i] && ({1'b0, w_off} < r_count)) w_pending[r_q_rd[i]] = 1'b1;
      end
   end

   assign bus.o_ld_ready  = w_ld_ready;
   assign bus.o_w_reg_num = r_w_reg_num;
   assign bus.o_w_val     = r_w_val;
   assign bus.o_op        = r_op;
   assign bus.o_pending   = w_pending;
   assign bus.o_count     = r_count;
endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_writeback_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

   reg_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] val;
   } wr_t;

   wr_t         exp_alu [$];
   wr_t         exp_ld  [$];
   wr_t         m_e;
   wr_t         m_keep  [$];
   logic [31:0] last_wr [32];
   logic        alu_last = 1'b0;
   int          n_chk = 0;
   int          n_err = 0;
   bit          acc;
   int          ldi;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // scoreboard: check the write produced by the last edge, then record what
   // the inputs now presented will cause at the next edge
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_alu.delete();
         exp_ld.delete();
         alu_last = 1'b0;
      end else begin
         if (alu_last) begin
            chk("alu_op", {63'd0, bus.o_op}, 64'd1);
            if (exp_alu.size() > 0) begin
               m_e = exp_alu.pop_front();
               chk("alu_rd",  {59'd0, bus.o_w_reg_num}, {59'd0, m_e.rd});
               chk("alu_val", {32'd0, bus.o_w_val}, {32'd0, m_e.val});
            end else begin
               chk("alu_exp_avail", 64'(exp_alu.size()), 64'd1);
            end
         end else if (bus.o_op) begin
            if (exp_ld.size() > 0) begin
               m_e = exp_ld.pop_front();
               chk("ld_rd",  {59'd0, bus.o_w_reg_num}, {59'd0, m_e.rd});
               chk("ld_val", {32'd0, bus.o_w_val}, {32'd0, m_e.val});
            end else begin
               chk("spurious_wr", {63'd0, bus.o_op}, 64'd0);
            end
         end
         if (bus.o_op) last_wr[bus.o_w_reg_num] = bus.o_w_val;

         alu_last = bus.i_alu_valid && (bus.i_alu_rd != 5'd0);
         if (alu_last) begin
            m_keep.delete();
            foreach (exp_ld[k]) if (exp_ld[k].rd != bus.i_alu_rd) m_keep.push_back(exp_ld[k]);
            exp_ld = m_keep;
            exp_alu.push_back({bus.i_alu_rd, bus.i_alu_val});
         end
         if (bus.i_ld_valid && bus.o_ld_ready && (bus.i_ld_rd != 5'd0) &&
             !(alu_last && (bus.i_ld_rd == bus.i_alu_rd)))
            exp_ld.push_back({bus.i_ld_rd, bus.i_ld_val});
      end
   end

   task automatic step(output bit a);
      a = bus.i_ld_valid && bus.o_ld_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic drv_alu(input logic [4:0] rd, input logic [31:0] v);
      bus.i_alu_valid = 1'b1;
      bus.i_alu_rd    = rd;
      bus.i_alu_val   = v;
   endtask

   task automatic drv_ld(input logic [4:0] rd, input logic [31:0] v);
      bus.i_ld_valid = 1'b1;
      bus.i_ld_rd    = rd;
      bus.i_ld_val   = v;
   endtask

   task automatic drv_idle();
      bus.i_alu_valid = 1'b0;
      bus.i_ld_valid  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      foreach (last_wr[k]) last_wr[k] = '0;
      bus.i_alu_valid = 1'b0;
      bus.i_alu_rd    = '0;
      bus.i_alu_val   = '0;
      bus.i_ld_valid  = 1'b0;
      bus.i_ld_rd     = '0;
      bus.i_ld_val    = '0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_op",      {63'd0, bus.o_op}, 64'd0);
      chk("rst_reg",     {59'd0, bus.o_w_reg_num}, 64'd0);
      chk("rst_val",     {32'd0, bus.o_w_val}, 64'd0);
      chk("rst_count",   64'(bus.o_count), 64'd0);
      chk("rst_pending", {32'd0, bus.o_pending}, 64'd0);
      chk("rst_ready",   {63'd0, bus.o_ld_ready}, 64'd1);
      rst_n = 1'b1;

      // ALU write, one-cycle latency, single pulse
      drv_alu(5'd5, 32'hDEADBEEF);
      step(acc);
      drv_idle();
      chk("t1_op",  {63'd0, bus.o_op}, 64'd1);
      chk("t1_reg", {59'd0, bus.o_w_reg_num}, 64'd5);
      chk("t1_val", {32'd0, bus.o_w_val}, 64'hDEADBEEF);
      step(acc);
      chk("t1_op_drop", {63'd0, bus.o_op}, 64'd0);

      // direct-path load
      drv_ld(5'd7, 32'h11);
      step(acc);
      drv_idle();
      chk("t2_acc",   {63'd0, acc}, 64'd1);
      chk("t2_op",    {63'd0, bus.o_op}, 64'd1);
      chk("t2_reg",   {59'd0, bus.o_w_reg_num}, 64'd7);
      chk("t2_val",   {32'd0, bus.o_w_val}, 64'h11);
      chk("t2_count", 64'(bus.o_count), 64'd0);
      step(acc);

      // sustained ALU traffic fills the queue; loads held at full
      ldi = 10;
      for (int c = 0; c < 6; c++) begin
         drv_alu(5'(c + 1), 32'h100 + 32'(c));
         if (ldi <= 14) drv_ld(5'(ldi), 32'h200 + 32'(ldi));
         else bus.i_ld_valid = 1'b0;
         step(acc);
         if (acc) ldi++;
         if (c == 3) begin
            chk("t3_count_full", 64'(bus.o_count), 64'd4);
            chk("t3_ready_low",  {63'd0, bus.o_ld_ready}, 64'd0);
         end
         if (c == 5) chk("t3_held", 64'(ldi), 64'd14);
      end
      bus.i_alu_valid = 1'b0;
      step(acc);
      if (acc) ldi++;
      chk("t3_pop_count", 64'(bus.o_count), 64'd3);
      chk("t3_ready_up",  {63'd0, bus.o_ld_ready}, 64'd1);
      for (int c = 0; c < 4 && ldi <= 14; c++) begin
         drv_ld(5'(ldi), 32'h200 + 32'(ldi));
         step(acc);
         if (acc) ldi++;
      end
      bus.i_ld_valid = 1'b0;
      for (int c = 0; c < 10 && bus.o_count != 0; c++) step(acc);
      chk("t3_drained", 64'(bus.o_count), 64'd0);
      chk("t3_ready",   {63'd0, bus.o_ld_ready}, 64'd1);
      step(acc);

      // kill a queued load by a younger ALU write
      drv_alu(5'd20, 32'h1);
      drv_ld(5'd8, 32'hAA);
      step(acc);
      bus.i_ld_valid = 1'b0;
      chk("t4_count",   64'(bus.o_count), 64'd1);
      chk("t4_pend_on", {63'd0, bus.o_pending[8]}, 64'd1);
      drv_alu(5'd8, 32'hBB);
      step(acc);
      drv_idle();
      chk("t4_pend_off", {63'd0, bus.o_pending[8]}, 64'd0);
      chk("t4_count2",   64'(bus.o_count), 64'd1);
      chk("t4_reg",      {59'd0, bus.o_w_reg_num}, 64'd8);
      chk("t4_val",      {32'd0, bus.o_w_val}, 64'hBB);
      step(acc);
      chk("t4_killed_op", {63'd0, bus.o_op}, 64'd0);
      chk("t4_count0",    64'(bus.o_count), 64'd0);
      step(acc);

      // same-cycle ALU and load to one register; load to x0
      drv_alu(5'd9, 32'd3);
      drv_ld(5'd9, 32'd4);
      step(acc);
      drv_idle();
      chk("t5_val",     {32'd0, bus.o_w_val}, 64'd3);
      chk("t5_count",   64'(bus.o_count), 64'd0);
      chk("t5_pending", {32'd0, bus.o_pending}, 64'd0);
      step(acc);
      chk("t5_op_idle", {63'd0, bus.o_op}, 64'd0);
      drv_ld(5'd0, 32'd5);
      step(acc);
      drv_idle();
      chk("t5_x0_acc",   {63'd0, acc}, 64'd1);
      chk("t5_x0_op",    {63'd0, bus.o_op}, 64'd0);
      chk("t5_x0_count", 64'(bus.o_count), 64'd0);
      step(acc);

      // reset mid-stream flushes queued loads
      for (int c = 0; c < 3; c++) begin
         drv_alu(5'(c + 1), 32'h300 + 32'(c));
         drv_ld(5'(21 + c), 32'h400 + 32'(c));
         step(acc);
         chk("t6_acc", {63'd0, acc}, 64'd1);
      end
      drv_idle();
      chk("t6_count",   64'(bus.o_count), 64'd3);
      chk("t6_pending", {32'd0, bus.o_pending}, 64'h0000_0000_00E0_0000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_count",   64'(bus.o_count), 64'd0);
      chk("t6_rst_pending", {32'd0, bus.o_pending}, 64'd0);
      chk("t6_rst_op",      {63'd0, bus.o_op}, 64'd0);
      chk("t6_rst_ready",   {63'd0, bus.o_ld_ready}, 64'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step(acc);
         chk("t6_no_wr", {63'd0, bus.o_op}, 64'd0);
      end

      @(negedge clk);
      #1;
      chk("end_alu_q", 64'(exp_alu.size()), 64'd0);
      chk("end_ld_q",  64'(exp_ld.size()), 64'd0);
      chk("end_x8",    {32'd0, last_wr[8]}, 64'hBB);
      chk("end_x9",    {32'd0, last_wr[9]}, 64'd3);
      chk("end_x13",   {32'd0, last_wr[13]}, 64'h20D);
      chk("end_x21",   {32'd0, last_wr[21]}, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
